// File: rtl/fifo8x9_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo8x9_ctrl_if
// Handshake and strobe bundle between the datapath, the fifo8x9_ctrl
// sequencer and the 8x9 FIFO storage block.
//   master : datapath side (drives push_req/pop_req/flush, observes status)
//   slave  : sequencer side (consumes requests, drives strobes and status)
// Signals:
//   push_req, pop_req, flush          requests from the datapath
//   push_ready, pop_ready             acceptance for this cycle
//   wren, WrInc, rden, RdInc          FIFO enable/increment strobes
//   WrPtrClr, RdPtrClr                FIFO pointer clears
//   pop_valid                         FIFO DataOut holds popped data
//   full, empty, count                occupancy status
//   wr_idx, rd_idx                    mirrors of the FIFO pointers
//   overflow, underflow               sticky rejection flags
// ---------------------------------------------------------------------------
interface fifo8x9_ctrl_if #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 4
);
    logic             push_req;
    logic             pop_req;
    logic             flush;
    logic             push_ready;
    logic             pop_ready;
    logic             wren;
    logic             WrInc;
    logic             rden;
    logic             RdInc;
    logic             WrPtrClr;
    logic             RdPtrClr;
    logic             pop_valid;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             overflow;
    logic             underflow;

    modport master (
        output push_req, pop_req, flush,
        input  push_ready, pop_ready, wren, WrInc, rden, RdInc,
               WrPtrClr, RdPtrClr, pop_valid, full, empty, count,
               wr_idx, rd_idx, overflow, underflow
    );

    modport slave (
        input  push_req, pop_req, flush,
        output push_ready, pop_ready, wren, WrInc, rden, RdInc,
               WrPtrClr, RdPtrClr, pop_valid, full, empty, count,
               wr_idx, rd_idx, overflow, underflow
    );
endinterface

// File: rtl/fifo8x9_ctrl.sv
// ---------------------------------------------------------------------------
// fifo8x9_ctrl
// Sequencer for the 8-entry x 9-bit FIFO storage block. Turns producer push
// and consumer pop requests into wren/WrInc and rden/RdInc strobes, keeps
// the occupancy count and mirrors of both FIFO pointers, and reports
// full/empty/pop_valid plus sticky overflow/underflow flags. The 9-bit data
// path goes straight to the FIFO and does not pass through here.
// Ports:
//   clk  rising-edge clock shared with the FIFO storage
//   rst  synchronous active-high reset
//   bus  fifo8x9_ctrl_if slave modport (requests in, strobes/status out)
// ---------------------------------------------------------------------------
module fifo8x9_ctrl #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    fifo8x9_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_CLR = 2'b00;
    localparam logic [1:0] ST_RUN = 2'b01;

    logic [1:0]       state;
    logic [1:0]       state_nxt;

    logic             in_run;
    logic             push_ready;
    logic             pop_ready;
    logic             acc_push;
    logic             acc_pop;
    logic             ptr_clr;

    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             pop_vld_p1;
    logic             overflow;
    logic             underflow;
    logic             full;
    logic             empty;

    // Pointer advance modulo DEPTH, so DEPTH need not be a power of two.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: CLR always lasts one cycle; illegal encodings recover to CLR.
    always_comb begin
        state_nxt = ST_CLR;
        case (state)
            ST_CLR:  state_nxt = ST_RUN;
            ST_RUN:  state_nxt = bus.flush ? ST_CLR : ST_RUN;
            default: state_nxt = ST_CLR;
        endcase
    end

    // Outputs: strobes are combinational on the request so the FIFO sees
    // the enable in the same cycle the request is accepted.
    always_comb begin
        in_run     = (state == ST_RUN) && !rst;
        push_ready = in_run && !full  && !bus.flush;
        pop_ready  = in_run && !empty && !bus.flush;
        acc_push   = bus.push_req && push_ready;
        acc_pop    = bus.pop_req  && pop_ready;
        ptr_clr    = rst || (state != ST_RUN);
    end

    // Occupancy, pointer mirrors, read-data valid and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            pop_vld_p1 <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            // FIFO DataOut is registered: valid one cycle after the pop,
            // independent of any flush that follows.
            pop_vld_p1 <= acc_pop;

            // Rejections while flushing count too; CLR/reset cycles do not.
            if (in_run && bus.push_req && !push_ready) begin
                overflow <= 1'b1;
            end
            if (in_run && bus.pop_req && !pop_ready) begin
                underflow <= 1'b1;
            end

            // Anything other than a non-flushing RUN cycle leaves the FIFO
            // pointers cleared, so the mirrors follow.
            if (state != ST_RUN || bus.flush) begin
                count  <= '0;
                wr_idx <= '0;
                rd_idx <= '0;
            end else begin
                if (acc_push) begin
                    wr_idx <= idx_inc(wr_idx);
                end
                if (acc_pop) begin
                    rd_idx <= idx_inc(rd_idx);
                end
                case ({acc_push, acc_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    assign bus.push_ready = push_ready;
    assign bus.pop_ready  = pop_ready;
    assign bus.wren       = acc_push;
    assign bus.WrInc      = acc_push;
    assign bus.rden       = acc_pop;
    assign bus.RdInc      = acc_pop;
    assign bus.WrPtrClr   = ptr_clr;
    assign bus.RdPtrClr   = ptr_clr;
    assign bus.pop_valid  = pop_vld_p1;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.count      = count;
    assign bus.wr_idx     = wr_idx;
    assign bus.rd_idx     = rd_idx;
    assign bus.overflow   = overflow;
    assign bus.underflow  = underflow;

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo8x9_ctrl
// Bench for fifo8x9_ctrl: a table of hand-derived vectors, hand-written
// corner-case sequences and randomized traffic against a queue-based model.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_fifo8x9_ctrl;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo8x9_ctrl_if #(.DEPTH(8), .IDX_W(3), .CNT_W(4)) bus ();

    fifo8x9_ctrl #(.DEPTH(8), .IDX_W(3), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue, pointers as running totals.
    bit m_run;
    int m_q[$];
    int m_pushes;
    int m_pops;
    bit m_pv;
    bit m_ov;
    bit m_un;
    // Inputs and acceptance of the cycle in progress
    bit c_r, c_pu, c_po, c_fl;
    bit e_pr, e_por, e_apush, e_apop;

    typedef struct {
        bit r, pu, po, fl;
        bit pr, por, wr, rd, clr, pv;
        int cnt, wi, ri;
        bit ov, un;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit pu, bit po, bit fl,
                                bit pr, bit por, bit wr, bit rd, bit clr, bit pv,
                                int cnt, int wi, int ri, bit ov, bit un);
        vec_t v;
        v.r = r; v.pu = pu; v.po = po; v.fl = fl;
        v.pr = pr; v.por = por; v.wr = wr; v.rd = rd; v.clr = clr; v.pv = pv;
        v.cnt = cnt; v.wi = wi; v.ri = ri; v.ov = ov; v.un = un;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_q.delete();
        m_pushes = 0;
        m_pops = 0;
        m_pv = 1'b0;
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    // Drive one cycle's inputs and compare every output with the model.
    task automatic apply(input bit r, input bit pu, input bit po, input bit fl);
        @(negedge clk);
        rst = r;
        bus.push_req = pu;
        bus.pop_req = po;
        bus.flush = fl;
        c_r = r; c_pu = pu; c_po = po; c_fl = fl;
        #1;
        e_pr    = !r && m_run && !fl && (m_q.size() < DEPTH);
        e_por   = !r && m_run && !fl && (m_q.size() > 0);
        e_apush = pu && e_pr;
        e_apop  = po && e_por;
        chk("push_ready", 32'(bus.push_ready), 32'(e_pr));
        chk("pop_ready",  32'(bus.pop_ready),  32'(e_por));
        chk("wren",       32'(bus.wren),       32'(e_apush));
        chk("WrInc",      32'(bus.WrInc),      32'(e_apush));
        chk("rden",       32'(bus.rden),       32'(e_apop));
        chk("RdInc",      32'(bus.RdInc),      32'(e_apop));
        chk("WrPtrClr",   32'(bus.WrPtrClr),   32'(r || !m_run));
        chk("RdPtrClr",   32'(bus.RdPtrClr),   32'(r || !m_run));
        chk("pop_valid",  32'(bus.pop_valid),  32'(m_pv));
        chk("full",       32'(bus.full),       32'(m_q.size() == DEPTH));
        chk("empty",      32'(bus.empty),      32'(m_q.size() == 0));
        chk("count",      32'(bus.count),      32'(m_q.size()));
        chk("wr_idx",     32'(bus.wr_idx),     32'(m_pushes % DEPTH));
        chk("rd_idx",     32'(bus.rd_idx),     32'(m_pops % DEPTH));
        chk("overflow",   32'(bus.overflow),   32'(m_ov));
        chk("underflow",  32'(bus.underflow),  32'(m_un));
    endtask

    // Advance the clock and the model across one rising edge.
    task automatic tick();
        int d;
        @(posedge clk);
        if (c_r) begin
            model_reset();
        end else begin
            m_pv = e_apop;
            if (m_run && c_pu && !e_pr) m_ov = 1'b1;
            if (m_run && c_po && !e_por) m_un = 1'b1;
            if (!m_run || c_fl) begin
                m_run = !m_run ? 1'b1 : 1'b0;
                m_q.delete();
                m_pushes = 0;
                m_pops = 0;
            end else begin
                if (e_apop) begin
                    d = m_q.pop_front();
                    m_pops++;
                end
                if (e_apush) begin
                    m_q.push_back(m_pushes);
                    m_pushes++;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit pu, input bit po, input bit fl);
        apply(r, pu, po, fl);
        tick();
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    initial begin
        bus.push_req = 1'b0;
        bus.pop_req = 1'b0;
        bus.flush = 1'b0;
        c_r = 1; c_pu = 0; c_po = 0; c_fl = 0;
        e_pr = 0; e_por = 0; e_apush = 0; e_apop = 0;
        model_reset();
        @(posedge clk);

        // ---- table: reset, idle, fill, overflow, drain, underflow ----
        //             r pu po fl  pr por wr rd clr pv cnt wi ri ov un
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 1, 0, 0, 1, (i > 0), 1, 0, 0, 0, i, i, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 8, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 0, 1, 0, (i > 0), 1, 0, 1, 0, (i > 0), 8 - i, 0, i, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].pu, tbl[i].po, tbl[i].fl);
            chk($sformatf("tbl%0d.push_ready", i), 32'(bus.push_ready), 32'(tbl[i].pr));
            chk($sformatf("tbl%0d.pop_ready", i),  32'(bus.pop_ready),  32'(tbl[i].por));
            chk($sformatf("tbl%0d.wren", i),       32'(bus.wren),       32'(tbl[i].wr));
            chk($sformatf("tbl%0d.WrInc", i),      32'(bus.WrInc),      32'(tbl[i].wr));
            chk($sformatf("tbl%0d.rden", i),       32'(bus.rden),       32'(tbl[i].rd));
            chk($sformatf("tbl%0d.RdInc", i),      32'(bus.RdInc),      32'(tbl[i].rd));
            chk($sformatf("tbl%0d.WrPtrClr", i),   32'(bus.WrPtrClr),   32'(tbl[i].clr));
            chk($sformatf("tbl%0d.RdPtrClr", i),   32'(bus.RdPtrClr),   32'(tbl[i].clr));
            chk($sformatf("tbl%0d.pop_valid", i),  32'(bus.pop_valid),  32'(tbl[i].pv));
            chk($sformatf("tbl%0d.count", i),      32'(bus.count),      32'(tbl[i].cnt));
            chk($sformatf("tbl%0d.wr_idx", i),     32'(bus.wr_idx),     32'(tbl[i].wi));
            chk($sformatf("tbl%0d.rd_idx", i),     32'(bus.rd_idx),     32'(tbl[i].ri));
            chk($sformatf("tbl%0d.overflow", i),   32'(bus.overflow),   32'(tbl[i].ov));
            chk($sformatf("tbl%0d.underflow", i),  32'(bus.underflow),  32'(tbl[i].un));
            tick();
        end

        // ---- simultaneous push/pop at count 3 ----
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0);
        apply(0, 0, 0, 0);
        chk("sim.count",  32'(bus.count),  32'd3);
        chk("sim.wr_idx", 32'(bus.wr_idx), 32'd7);
        chk("sim.rd_idx", 32'(bus.rd_idx), 32'd4);
        tick();

        // ---- both requests at full ----
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
        apply(0, 1, 1, 0);
        chk("full_both.rden", 32'(bus.rden), 32'd1);
        chk("full_both.wren", 32'(bus.wren), 32'd0);
        tick();
        apply(0, 0, 0, 0);
        chk("full_both.count",    32'(bus.count),    32'd7);
        chk("full_both.overflow", 32'(bus.overflow), 32'd1);
        tick();

        // ---- both requests at empty ----
        do_reset();
        apply(0, 1, 1, 0);
        chk("empty_both.wren", 32'(bus.wren), 32'd1);
        chk("empty_both.rden", 32'(bus.rden), 32'd0);
        tick();
        apply(0, 0, 0, 0);
        chk("empty_both.count",     32'(bus.count),     32'd1);
        chk("empty_both.underflow", 32'(bus.underflow), 32'd1);
        chk("empty_both.overflow",  32'(bus.overflow),  32'd0);
        tick();

        // ---- flush with a push request at count 5 ----
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        apply(0, 1, 0, 1);
        chk("flush.wren",       32'(bus.wren),       32'd0);
        chk("flush.push_ready", 32'(bus.push_ready), 32'd0);
        tick();
        apply(0, 0, 0, 0);
        chk("flush.clr_wr",   32'(bus.WrPtrClr), 32'd1);
        chk("flush.clr_rd",   32'(bus.RdPtrClr), 32'd1);
        chk("flush.count",    32'(bus.count),    32'd0);
        chk("flush.wr_idx",   32'(bus.wr_idx),   32'd0);
        chk("flush.overflow", 32'(bus.overflow), 32'd1);
        tick();
        apply(0, 0, 0, 0);
        chk("flush.run_clr",    32'(bus.WrPtrClr),   32'd0);
        chk("flush.push_ready", 32'(bus.push_ready), 32'd1);
        tick();

        // ---- pop right before flush keeps its pop_valid pulse ----
        do_reset();
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        apply(0, 0, 1, 1);
        chk("popflush.pop_valid", 32'(bus.pop_valid), 32'd1);
        chk("popflush.rden",      32'(bus.rden),      32'd0);
        tick();
        apply(0, 0, 0, 0);
        chk("popflush.pop_valid_after", 32'(bus.pop_valid), 32'd0);
        chk("popflush.underflow",       32'(bus.underflow), 32'd1);
        tick();

        // ---- randomized traffic with phase-varying push/pop bias ----
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int bias;
            bias = ((i / 150) % 2 == 0) ? 70 : 30;
            step($urandom_range(199) == 0,
                 $urandom_range(99) < bias,
                 $urandom_range(99) < (100 - bias),
                 $urandom_range(39) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo8x9_ctrl.md
Name: fifo8x9_ctrl

Overview:
Control sequencer that drives the pointer and enable inputs of the 8-entry x 9-bit FIFO storage block (wren, WrInc, rden, RdInc, WrPtrClr, RdPtrClr). It converts producer push requests and consumer pop requests into correctly timed FIFO strobes. It tracks occupancy and mirrors the FIFO write and read indices, and reports full, empty, data-valid and error status to the surrounding datapath. It sits between the datapath and the FIFO storage; the 9-bit data path connects directly to the FIFO and does not pass through this block.

Parameters:
DEPTH, 8, number of FIFO entries; must equal the storage depth.
IDX_W, 3, index width; equals log2(DEPTH).
CNT_W, 4, occupancy counter width; equals IDX_W+1, range 0..DEPTH.

Ports:
clk  in  1  rising-edge clock, shared with the FIFO storage block.
rst  in  1  synchronous, active-high reset.
push_req  in  1  producer requests a write of DataIn this cycle.
pop_req  in  1  consumer requests a read this cycle.
flush  in  1  discard all contents and clear both pointers.
push_ready  out  1  a push is accepted this cycle if push_req is high.
pop_ready  out  1  a pop is accepted this cycle if pop_req is high.
wren  out  1  FIFO write enable.
WrInc  out  1  FIFO write-pointer increment.
rden  out  1  FIFO read enable.
RdInc  out  1  FIFO read-pointer increment.
WrPtrClr  out  1  FIFO write-pointer clear.
RdPtrClr  out  1  FIFO read-pointer clear.
pop_valid  out  1  FIFO DataOut holds popped data this cycle.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
count  out  CNT_W  current occupancy.
wr_idx  out  IDX_W  mirror of the FIFO write pointer.
rd_idx  out  IDX_W  mirror of the FIFO read pointer.
overflow  out  1  sticky flag: a push was rejected.
underflow  out  1  sticky flag: a pop was rejected.

Behaviour:
- States: CLR (2'b00) and RUN (2'b01). Encodings 2'b10 and 2'b11 are illegal and return to CLR on the next edge.
- rst=1 at an edge sets: state=CLR, count=0, wr_idx=0, rd_idx=0, pop_valid=0, overflow=0, underflow=0.
- CLR state: WrPtrClr=RdPtrClr=1; push_ready=pop_ready=0; all enables 0. Next state is RUN unconditionally, so CLR lasts exactly one cycle.
- While rst=1 (combinational): WrPtrClr=RdPtrClr=1; every other strobe is 0.
- RUN state readiness: push_ready = !full && !flush; pop_ready = !empty && !flush.
- Accepted push (acc_push = push_req & push_ready): wren=WrInc=1 in the same cycle (combinational). wr_idx increments modulo DEPTH, so 7 wraps to 0.
- Accepted pop (acc_pop = pop_req & pop_ready): rden=RdInc=1 in the same cycle. rd_idx increments modulo DEPTH. pop_valid=1 on the following cycle only (the FIFO DataOut is registered, so latency is 1).
- When a strobe is not asserted, wren, WrInc, rden and RdInc are all 0. The block never asserts an enable without its matching increment.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both indices advance.
- Push and pop in the same cycle are legal only when 0 < count < DEPTH.
  - When full, pop is accepted and push is rejected.
  - When empty, push is accepted and pop is rejected.
- overflow is set when push_req=1 and push_ready=0 in RUN, including rejections caused by flush. It stays set until rst.
- underflow follows the same rule for pop_req and pop_ready.
- Requests arriving while in CLR or during rst do not set either flag.
- flush=1 in RUN: no push or pop is accepted that cycle. On the next edge: state=CLR, count=0, wr_idx=0, rd_idx=0. Sticky flags are kept.
- A pop accepted in the cycle before a flush still produces its pop_valid pulse; pop_valid is never suppressed by flush.
- Invariant: full and empty are never both 1. count is never greater than DEPTH.

Test Plan:
- Reset then idle: hold rst for 2 cycles, then release. Required: WrPtrClr=RdPtrClr=1 during rst and for one CLR cycle after; then empty=1, count=0, push_ready=1, pop_ready=0.
- Fill: 8 consecutive push_req cycles. Required: wren/WrInc high on each; wr_idx steps 1..7 then 0; full=1 with count=8. A 9th push gives push_ready=0, no wren, and overflow=1.
- Drain: from full, 8 consecutive pop_req cycles. Required: rden/RdInc high on each; pop_valid high in cycles 2..9; empty=1 and count=0 after the last pop. A 9th pop sets underflow=1 with no rden.
- Simultaneous: with count=3, push_req and pop_req together for 4 cycles. Required: count stays 3; wr_idx and rd_idx both advance by 4 (mod 8).
- Boundary simultaneous: at full, push_req and pop_req together. Required: pop accepted, push rejected, count=7, overflow=1. At empty, both together: push accepted, count=1, underflow=1.
- Flush mid-operation: count=5 with push_req=1 and flush=1 in the same cycle. Required: no wren that cycle; then one CLR cycle with both clears high; then count=0, indices 0, overflow=1 retained.
